// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int CAUSE_W = 2;
   localparam int CNT_W   = 32;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_MISALIGN = 2'b01,
      FC_RANGE    = 2'b10
   } fault_cause_e;

   // Misalignment outranks out-of-range when a PC is wrong both ways.
   function automatic fault_cause_e classify_pc(input logic [1:0] pc_lsb,
                                                input logic       out_of_range);
      fault_cause_e c;
      c = FC_NONE;
      if (pc_lsb != 2'b00) begin
         c = FC_MISALIGN;
      end else if (out_of_range) begin
         c = FC_RANGE;
      end
      return c;
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry prefetch FIFO holding {pc, inst}; flush beats push and pop.
module fetch_buf #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic [W-1:0] last_head;
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt;

   // Pointers and occupancy; a flush empties the FIFO regardless of push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage is cleared on reset so the head output is never unknown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   // Remember the most recent head so an empty FIFO keeps showing it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_head <= '0;
      end else begin
         last_head <= head;
      end
   end

   // Head mux: live entry when occupied, otherwise the held copy.
   always_comb begin
      head = (cnt == 2'd0) ? last_head : mem[rd_ptr];
   end

   assign full  = (cnt == 2'd2);
   assign empty = (cnt == 2'd0);
   assign count = cnt;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch PC sequencer: drives the instruction memory, buffers returned words,
// hands them to decode, and turns illegal fetch PCs into a drained fault.
module imem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                    INST_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    IMEM_WORDS = 1 << 18,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   input  logic [INST_WIDTH-1:0] i_imem_data,
   output logic                  o_inst_valid,
   input  logic                  i_inst_ready,
   output logic [INST_WIDTH-1:0] o_inst,
   output logic [ADDR_WIDTH-1:0] o_inst_pc,
   input  logic                  i_redirect_valid,
   input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
   output logic                  o_fault,
   output logic [CAUSE_W-1:0]    o_fault_cause,
   output logic [ADDR_WIDTH-1:0] o_fault_pc,
   output logic [CNT_W-1:0]      o_fetch_cnt
);

   // First byte address past the end of instruction memory.
   localparam longint unsigned LIMIT = 64'(IMEM_WORDS) * 64'd4;
   localparam int              ENT_W = ADDR_WIDTH + INST_WIDTH;

   logic [ADDR_WIDTH-1:0] pc_q;
   fetch_state_e          state_q;
   fault_cause_e          cause_q;
   logic [ADDR_WIDTH-1:0] fpc_q;
   logic [CNT_W-1:0]      cnt_q;

   fault_cause_e          pc_cause;
   logic                  pc_legal;
   logic                  buf_full;
   logic                  buf_empty;
   logic [1:0]            buf_count;
   logic [ENT_W-1:0]      buf_head;
   logic                  deq;
   logic                  enq;

   assign pc_cause = classify_pc(pc_q[1:0], (64'(pc_q) >= LIMIT));
   assign pc_legal = (pc_cause == FC_NONE);

   // A redirect hides the head for its cycle so nothing older slips through.
   assign o_inst_valid = !buf_empty && !i_redirect_valid && (state_q != FAULT);
   assign deq          = o_inst_valid && i_inst_ready;
   assign enq          = (state_q == RUN) && pc_legal && !i_redirect_valid &&
                         (!buf_full || deq);

   fetch_buf #(
      .W (ENT_W)
   ) u_buf (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (enq),
      .pop   (deq),
      .flush (i_redirect_valid),
      .din   ({pc_q, i_imem_data}),
      .head  (buf_head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   assign o_inst_pc = buf_head[ENT_W-1:INST_WIDTH];
   assign o_inst    = buf_head[INST_WIDTH-1:0];

   // Fetch PC: jumps on redirect, steps a word on every enqueue.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q <= RESET_PC;
      end else if (i_redirect_valid) begin
         pc_q <= i_redirect_pc;
      end else if (enq) begin
         pc_q <= pc_q + ADDR_WIDTH'(4);
      end
   end

   // RUN/DRAIN/FAULT sequencing with the fault cause and PC latched on entry.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= RUN;
         cause_q <= FC_NONE;
         fpc_q   <= '0;
      end else if (i_redirect_valid) begin
         state_q <= RUN;
         cause_q <= FC_NONE;
         fpc_q   <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (!pc_legal) begin
                  state_q <= DRAIN;
                  cause_q <= pc_cause;
                  fpc_q   <= pc_q;
               end
            end
            DRAIN: begin
               // Older buffered words finish first; the last pop counts as empty.
               if ((buf_count == 2'd0) || ((buf_count == 2'd1) && deq)) begin
                  state_q <= FAULT;
               end
            end
            FAULT: begin
               state_q <= FAULT;
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   // Accepted-instruction counter, wrapping naturally.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else if (deq) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign o_imem_addr   = pc_q;
   assign o_fault       = (state_q == FAULT);
   assign o_fault_cause = (state_q == FAULT) ? cause_q : FC_NONE;
   assign o_fault_pc    = (state_q == FAULT) ? fpc_q : '0;
   assign o_fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_imem_fetch_ctrl;

   logic        i_clk;
   logic        i_rst_n;
   logic [31:0] o_imem_addr;
   logic [31:0] i_imem_data;
   logic        o_inst_valid;
   logic        i_inst_ready;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;
   logic        o_fault;
   logic [1:0]  o_fault_cause;
   logic [31:0] o_fault_pc;
   logic [31:0] o_fetch_cnt;

   imem_fetch_ctrl dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .o_imem_addr      (o_imem_addr),
      .i_imem_data      (i_imem_data),
      .o_inst_valid     (o_inst_valid),
      .i_inst_ready     (i_inst_ready),
      .o_inst           (o_inst),
      .o_inst_pc        (o_inst_pc),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_fault          (o_fault),
      .o_fault_cause    (o_fault_cause),
      .o_fault_pc       (o_fault_pc),
      .o_fetch_cnt      (o_fetch_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Memory contents: constant NOP in streaming mode, address hash otherwise.
   logic mem_mode;
   function automatic logic [31:0] memword(input logic [31:0] a);
      if (mem_mode) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction
   always_comb i_imem_data = memword(o_imem_addr);

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   localparam longint unsigned M_LIMIT = 64'd4 * (64'd1 << 18);

   ent_t        q[$];
   logic [31:0] m_pc;
   int          m_st;      // 0 run, 1 drain, 2 fault
   logic [1:0]  m_cause;
   logic [31:0] m_fpc;
   logic [31:0] m_cnt;
   logic        cur_rdy, cur_rv;
   logic [31:0] cur_rpc;

   task automatic model_reset();
      q.delete();
      m_pc = 32'h0; m_st = 0; m_cause = 2'b00; m_fpc = 32'h0; m_cnt = 32'h0;
   endtask

   function automatic logic m_valid();
      return (q.size() > 0) && !cur_rv && (m_st != 2);
   endfunction

   task automatic model_check();
      logic ev;
      ev = m_valid();
      chk("valid", {31'b0, o_inst_valid}, {31'b0, ev});
      chk("imem_addr", o_imem_addr, m_pc);
      chk("fault", {31'b0, o_fault}, {31'b0, (m_st == 2)});
      chk("fault_cause", {30'b0, o_fault_cause}, (m_st == 2) ? {30'b0, m_cause} : 32'h0);
      chk("fault_pc", o_fault_pc, (m_st == 2) ? m_fpc : 32'h0);
      chk("fetch_cnt", o_fetch_cnt, m_cnt);
      if (ev) begin
         chk("inst_pc", o_inst_pc, q[0].pc);
         chk("inst", o_inst, q[0].inst);
      end
   endtask

   task automatic model_step();
      int  old;
      logic mis, rng;
      if (cur_rv) begin
         q.delete();
         m_pc = cur_rpc; m_st = 0; m_cause = 2'b00; m_fpc = 32'h0;
         return;
      end
      old = m_st;
      if (m_valid() && cur_rdy) begin
         void'(q.pop_front());
         m_cnt = m_cnt + 32'd1;
      end
      mis = (m_pc % 4) != 0;
      rng = 64'(m_pc) >= M_LIMIT;
      if (old == 0) begin
         if (mis || rng) begin
            m_st = 1;
            m_cause = mis ? 2'b01 : 2'b10;
            m_fpc = m_pc;
         end else if (q.size() < 2) begin
            q.push_back('{pc: m_pc, inst: memword(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end else if (old == 1 && q.size() == 0) begin
         m_st = 2;
      end
   endtask

   // One clock: drive at posedge+1, check at negedge, advance model at posedge.
   task automatic cyc_begin(input logic rdy, input logic rv, input logic [31:0] rpc);
      cur_rdy = rdy; cur_rv = rv; cur_rpc = rpc;
      i_inst_ready = rdy; i_redirect_valid = rv; i_redirect_pc = rpc;
      @(negedge i_clk);
      model_check();
   endtask

   task automatic cyc_end();
      model_step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic apply_reset();
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] eaddr;
      logic        ef;
      logic [1:0]  ecause;
      logic [31:0] efpc;
      logic [31:0] ecnt;
   } vec_t;

   vec_t tbl [0:17];

   initial begin
      // back-pressure, release, redirect with full buffer, misaligned redirect
      tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1'b0, 2'd0, 32'h0,   32'd0};
      tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h4,   1'b0, 2'd0, 32'h0,   32'd0};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8,   1'b0, 2'd0, 32'h0,   32'd0};
      tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8,   1'b0, 2'd0, 32'h0,   32'd0};
      tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8,   1'b0, 2'd0, 32'h0,   32'd0};
      tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8,   1'b0, 2'd0, 32'h0,   32'd0};
      tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   32'hC,   1'b0, 2'd0, 32'h0,   32'd1};
      tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10,  1'b0, 2'd0, 32'h0,   32'd2};
      tbl[8]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h14,  1'b0, 2'd0, 32'h0,   32'd3};
      tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h100, 1'b0, 2'd0, 32'h0,   32'd3};
      tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 32'h104, 1'b0, 2'd0, 32'h0,   32'd3};
      tbl[11] = '{1'b0, 1'b1, 32'h102, 1'b0, 32'h0,   32'h108, 1'b0, 2'd0, 32'h0,   32'd4};
      tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h102, 1'b0, 2'd0, 32'h0,   32'd4};
      tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h102, 1'b0, 2'd0, 32'h0,   32'd4};
      tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h102, 1'b1, 2'd1, 32'h102, 32'd4};
      tbl[15] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h102, 1'b1, 2'd1, 32'h102, 32'd4};
      tbl[16] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h200, 1'b0, 2'd0, 32'h0,   32'd4};
      tbl[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 32'h204, 1'b0, 2'd0, 32'h0,   32'd4};
   end

   initial begin
      i_rst_n = 1'b0;
      i_inst_ready = 1'b0;
      i_redirect_valid = 1'b0;
      i_redirect_pc = 32'h0;
      cur_rdy = 1'b0; cur_rv = 1'b0; cur_rpc = 32'h0;
      mem_mode = 1'b1;
      model_reset();

      // reset values while reset is held
      #2;
      chk("rst_valid", {31'b0, o_inst_valid}, 32'h0);
      chk("rst_addr", o_imem_addr, 32'h0);
      chk("rst_fault", {31'b0, o_fault}, 32'h0);
      chk("rst_cause", {30'b0, o_fault_cause}, 32'h0);
      chk("rst_fault_pc", o_fault_pc, 32'h0);
      chk("rst_cnt", o_fetch_cnt, 32'h0);

      // streaming NOPs at full rate
      apply_reset();
      for (int k = 0; k < 12; k++) begin
         cyc_begin(1'b1, 1'b0, 32'h0);
         if (k >= 1) begin
            chk("stream_valid", {31'b0, o_inst_valid}, 32'h1);
            chk("stream_pc", o_inst_pc, 32'(4 * (k - 1)));
            chk("stream_inst", o_inst, 32'h0000_0013);
         end
         if (k == 11) chk("stream_cnt10", o_fetch_cnt, 32'd10);
         cyc_end();
      end

      // async reset mid-stream with one entry buffered
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("async_valid", {31'b0, o_inst_valid}, 32'h0);
      chk("async_cnt", o_fetch_cnt, 32'h0);
      chk("async_addr", o_imem_addr, 32'h0);
      apply_reset();
      cyc_begin(1'b1, 1'b0, 32'h0);
      cyc_end();
      cyc_begin(1'b1, 1'b0, 32'h0);
      chk("after_rst_pc", o_inst_pc, 32'h0);
      cyc_end();

      // directed table from a fresh reset
      mem_mode = 1'b0;
      apply_reset();
      for (int i = 0; i < 18; i++) begin
         cyc_begin(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
         chk($sformatf("tbl%0d_valid", i), {31'b0, o_inst_valid}, {31'b0, tbl[i].ev});
         if (tbl[i].ev) chk($sformatf("tbl%0d_pc", i), o_inst_pc, tbl[i].epc);
         chk($sformatf("tbl%0d_addr", i), o_imem_addr, tbl[i].eaddr);
         chk($sformatf("tbl%0d_fault", i), {31'b0, o_fault}, {31'b0, tbl[i].ef});
         chk($sformatf("tbl%0d_cause", i), {30'b0, o_fault_cause}, {30'b0, tbl[i].ecause});
         chk($sformatf("tbl%0d_fpc", i), o_fault_pc, tbl[i].efpc);
         chk($sformatf("tbl%0d_cnt", i), o_fetch_cnt, tbl[i].ecnt);
         cyc_end();
      end

      // run off the end of memory: last word delivered, then range fault
      cyc_begin(1'b1, 1'b1, 32'h000F_FFF8);
      cyc_end();
      for (int k = 1; k <= 5; k++) begin
         cyc_begin(1'b1, 1'b0, 32'h0);
         if (k == 2) chk("oor_pc_fff8", o_inst_pc, 32'h000F_FFF8);
         if (k == 3) begin
            chk("oor_last_valid", {31'b0, o_inst_valid}, 32'h1);
            chk("oor_pc_fffc", o_inst_pc, 32'h000F_FFFC);
         end
         if (k == 4) chk("oor_drain_nofault", {31'b0, o_fault}, 32'h0);
         if (k == 5) begin
            chk("oor_fault", {31'b0, o_fault}, 32'h1);
            chk("oor_cause", {30'b0, o_fault_cause}, 32'h2);
            chk("oor_fpc", o_fault_pc, 32'h0010_0000);
         end
         cyc_end();
      end
      cyc_begin(1'b1, 1'b1, 32'h0000_0040);
      cyc_end();

      // randomized traffic against the reference model
      for (int n = 0; n < 4000; n++) begin
         logic        rdy, rv;
         logic [31:0] rpc;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0: rpc = 32'($urandom_range(0, 1023)) << 2;
            1: rpc = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            2: rpc = 32'h000F_FFE0 + (32'($urandom_range(0, 7)) << 2);
            default: rpc = $urandom;
         endcase
         cyc_begin(rdy, rv, rpc);
         cyc_end();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
